// File: rtl/itof_arb_pkg.sv
// Shared types and the round-robin pick used by the itof arbiter and
// other shared FPU units.
package itof_arb_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int NSTAGE_DEF = 3;

    // Owner ids are sized for the largest supported requester count (8).
    localparam int ID_W = 3;
    typedef logic [ID_W-1:0] id_t;
    localparam id_t ID_ONE = 3'd1;

    typedef struct packed {
        logic v;
        id_t  id;
    } tag_t;

    // One-hot winner: first set bit of req searching upward from ptr, modulo n.
    function automatic logic [7:0] rr_pick(input logic [7:0] req, input id_t ptr, input int n);
        logic [7:0] pick;
        logic       found;
        int         idx;
        pick  = 8'h00;
        found = 1'b0;
        for (int j = 0; j < 8; j++) begin
            idx = int'(ptr) + j;
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            if ((j < n) && !found && req[3'(idx)]) begin
                pick[3'(idx)] = 1'b1;
                found         = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/itof_arbiter_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant plus a pointer that
// advances past the winner only when a grant is actually made.
module rr_arb
    import itof_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output id_t             grant_id
);

    id_t  ptr_r;
    id_t  ptr_nxt_s;
    logic xfer_s;

    // Grant selection, masked by the issue enable.
    always_comb begin
        grant = NREQ'(rr_pick(8'(req), ptr_r, NREQ)) & {NREQ{en}};
    end

    // Encode the one-hot grant; at most one bit is ever set.
    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_id = grant_id | (grant[i] ? id_t'(i) : '0);
        end
    end

    // Pointer successor: winner + 1 modulo NREQ.
    always_comb begin
        xfer_s    = |grant;
        ptr_nxt_s = (grant_id == id_t'(NREQ - 1)) ? '0 : grant_id + ID_ONE;
    end

    // Pointer register; holds when nothing is granted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_r <= '0;
        end else if (xfer_s) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/itof_arbiter.sv
// Shares one fixed-latency itof converter among NREQ requesters; a tag
// pipeline tracks each in-flight operand's owner so results return one-hot.
module itof_arbiter
    import itof_arb_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int NSTAGE = NSTAGE_DEF
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*32-1:0]            req_data,
    output logic [NREQ-1:0]               req_ready,
    output logic [31:0]                   fpu_x,
    input  logic [31:0]                   fpu_y,
    output logic [NREQ-1:0]               resp_valid,
    output logic [31:0]                   resp_data,
    output logic                          busy,
    output logic [$clog2(NSTAGE+1):0]     inflight
);

    localparam int IW = $clog2(NSTAGE + 1) + 1;
    localparam logic [NREQ-1:0] OH_ONE = {{(NREQ-1){1'b0}}, 1'b1};

    logic [NREQ-1:0] grant_s;
    id_t             grant_id_s;
    logic            xfer_s;
    logic [31:0]     sel_data_s;
    tag_t            tag_in_s;
    tag_t            tag_r [NSTAGE];
    logic [31:0]     fpu_x_r;
    logic [NREQ-1:0] resp_nxt_s;
    logic [NREQ-1:0] resp_valid_r;
    logic [31:0]     resp_data_r;
    logic [IW-1:0]   inflight_nxt_s;
    logic [IW-1:0]   inflight_r;
    logic            busy_r;

    rr_arb #(.NREQ(NREQ)) u_rr_arb (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .req      (req_valid),
        .grant    (grant_s),
        .grant_id (grant_id_s)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        xfer_s     = |grant_s;
        sel_data_s = 32'h0000_0000;
        for (int i = 0; i < NREQ; i++) begin
            sel_data_s = sel_data_s | (grant_s[i] ? req_data[32*i +: 32] : 32'h0000_0000);
        end
    end

    // Next tag, response strobe and occupancy derived from current state.
    always_comb begin
        tag_in_s.v     = xfer_s;
        tag_in_s.id    = grant_id_s;
        resp_nxt_s     = tag_r[NSTAGE-1].v ? (OH_ONE << tag_r[NSTAGE-1].id) : '0;
        inflight_nxt_s = inflight_r + IW'(tag_in_s.v) - IW'(tag_r[NSTAGE-1].v);
    end

    // Issue register: fpu_x only moves on a transfer to avoid needless toggling.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fpu_x_r <= 32'h0000_0000;
        end else if (xfer_s) begin
            fpu_x_r <= sel_data_s;
        end else begin
            fpu_x_r <= fpu_x_r;
        end
    end

    // Tag shift register, aligned stage-for-stage with the converter pipeline.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NSTAGE; k++) begin
                tag_r[k] <= '0;
            end
        end else begin
            tag_r[0] <= tag_in_s;
            for (int k = 1; k < NSTAGE; k++) begin
                tag_r[k] <= tag_r[k-1];
            end
        end
    end

    // Response register: data captured only when an owned result arrives.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_valid_r <= '0;
            resp_data_r  <= 32'h0000_0000;
        end else begin
            resp_valid_r <= resp_nxt_s;
            if (tag_r[NSTAGE-1].v) begin
                resp_data_r <= fpu_y;
            end else begin
                resp_data_r <= resp_data_r;
            end
        end
    end

    // Occupancy and busy, registered from their next-state values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_r <= '0;
            busy_r     <= 1'b0;
        end else begin
            inflight_r <= inflight_nxt_s;
            busy_r     <= (inflight_nxt_s != '0) | (|resp_nxt_s);
        end
    end

    assign req_ready  = grant_s;
    assign fpu_x      = fpu_x_r;
    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign busy       = busy_r;
    assign inflight   = inflight_r;

endmodule

// File: tb/tb_itof_arbiter.sv
// Randomised scoreboard bench for itof_arbiter with a behavioural itof stub.
module tb_itof_arbiter;

    localparam int NREQ   = 4;
    localparam int NSTAGE = 3;
    localparam int IW     = $clog2(NSTAGE + 1) + 1;
    localparam int DEPTH  = 256;

    logic                 clk;
    logic                 rstn;
    logic                 en;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*32-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [31:0]          fpu_x;
    logic [31:0]          fpu_y;
    logic [NREQ-1:0]      resp_valid;
    logic [31:0]          resp_data;
    logic                 busy;
    logic [IW-1:0]        inflight;

    itof_arbiter #(.NREQ(NREQ), .NSTAGE(NSTAGE)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fpu_x      (fpu_x),
        .fpu_y      (fpu_y),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .busy       (busy),
        .inflight   (inflight)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference int32 -> float32, round to nearest even.
    function automatic logic [31:0] ref_itof(input logic [31:0] x);
        logic        s;
        logic [63:0] a, keep, rem, half;
        int          e, sh;
        if (x == 32'h0) return 32'h0;
        s = x[31];
        a = s ? 64'(-x) & 64'hFFFF_FFFF : 64'(x);
        e = 31;
        while (a[e] == 1'b0) e--;
        if (e <= 23) begin
            keep = a << (23 - e);
        end else begin
            sh   = e - 23;
            keep = a >> sh;
            rem  = a & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
            if (keep == (64'd1 << 24)) begin
                keep = keep >> 1;
                e    = e + 1;
            end
        end
        return {s, 8'(127 + e), keep[22:0]};
    endfunction

    // itof stub: result sampled NSTAGE edges after the operand is registered.
    logic [31:0] stg [NSTAGE-1];
    always @(posedge clk) begin
        stg[0] <= ref_itof(fpu_x);
        for (int k = 1; k < NSTAGE - 1; k++) stg[k] <= stg[k-1];
    end
    assign fpu_y = stg[NSTAGE-2];

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [NREQ-1:0] own;
        logic [31:0]     data;
        int              due;
    } exp_t;
    exp_t sb_q[$];

    // Requester operand FIFOs; a requester is valid while its FIFO is non-empty.
    logic [31:0] src_mem [NREQ][DEPTH];
    int          head [NREQ];
    int          tail [NREQ];
    int          p_model = 0;
    logic [31:0] last_x = 32'h0;
    logic [31:0] last_data = 32'h0;

    task automatic push_src(input int i, input logic [31:0] d);
        if (tail[i] < DEPTH) begin
            src_mem[i][tail[i]] = d;
            tail[i]++;
        end
    endtask

    task automatic clear_model();
        sb_q.delete();
        p_model   = 0;
        last_x    = 32'h0;
        last_data = 32'h0;
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    // One cycle: drive requests, predict the grant, push the expected response.
    task automatic do_cycle();
        int w;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = (head[i] != tail[i]);
            req_data[32*i +: 32] = req_valid[i] ? src_mem[i][head[i]] : $urandom;
        end
        #1;
        w = -1;
        if (en) begin
            for (int j = 0; j < NREQ; j++) begin
                if (w < 0 && head[(p_model + j) % NREQ] != tail[(p_model + j) % NREQ])
                    w = (p_model + j) % NREQ;
            end
        end
        chk(req_ready == ((w >= 0) ? NREQ'(1) << w : NREQ'(0)), "req_ready", 64'(req_ready),
            (w >= 0) ? 64'(1) << w : 64'(0));
        if (w >= 0) begin
            sb_q.push_back('{own: NREQ'(1) << w, data: ref_itof(src_mem[w][head[w]]),
                             due: cyc + 1 + NSTAGE});
            last_x  = src_mem[w][head[w]];
            head[w]++;
            p_model = (w + 1) % NREQ;
        end
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever a response is due or presented.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_resp;
        int   exp_infl;
        if (rstn) begin
            exp_resp = (sb_q.size() > 0) && (sb_q[0].due == cyc);
            chk((resp_valid != '0) == exp_resp, "resp_valid_presence", 64'(resp_valid), 64'(exp_resp));
            if (exp_resp) begin
                e = sb_q.pop_front();
                chk(resp_valid == e.own, "resp_owner", 64'(resp_valid), 64'(e.own));
                last_data = e.data;
            end
            chk(resp_data == last_data, "resp_data", 64'(resp_data), 64'(last_data));
            chk(fpu_x == last_x, "fpu_x", 64'(fpu_x), 64'(last_x));
            exp_infl = 0;
            foreach (sb_q[k]) if (sb_q[k].due > cyc) exp_infl++;
            chk(int'(inflight) == exp_infl, "inflight", 64'(inflight), 64'(exp_infl));
            chk(busy == (exp_infl > 0 || exp_resp), "busy", 64'(busy), 64'(exp_infl > 0 || exp_resp));
        end
    end

    initial begin
        logic [31:0] edge_v [4];
        rstn      = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        req_data  = '0;
        clear_model();
        edge_v[0] = 32'hFFFF_FFFF;
        edge_v[1] = 32'h8000_0000;
        edge_v[2] = 32'h0000_0000;
        edge_v[3] = 32'h7FFF_FFFF;

        // Reference converter against known encodings.
        chk(ref_itof(edge_v[0]) == 32'hBF80_0000, "ref_neg1", 64'(ref_itof(edge_v[0])), 64'hBF80_0000);
        chk(ref_itof(edge_v[1]) == 32'hCF00_0000, "ref_min", 64'(ref_itof(edge_v[1])), 64'hCF00_0000);
        chk(ref_itof(edge_v[3]) == 32'h4F00_0000, "ref_max", 64'(ref_itof(edge_v[3])), 64'h4F00_0000);

        @(negedge clk);
        @(negedge clk);
        chk(fpu_x == 32'h0, "rst_fpu_x", 64'(fpu_x), 64'h0);
        chk(resp_valid == '0, "rst_resp_valid", 64'(resp_valid), 64'h0);
        chk(resp_data == 32'h0, "rst_resp_data", 64'(resp_data), 64'h0);
        chk(busy == 1'b0, "rst_busy", 64'(busy), 64'h0);
        chk(inflight == '0, "rst_inflight", 64'(inflight), 64'h0);
        rstn = 1'b1;
        en   = 1'b1;
        @(negedge clk);

        // Requester 0 alone.
        push_src(0, 32'h0000_0001);
        repeat (NSTAGE + 3) do_cycle();

        // Signed edge values from requester 1, back-to-back.
        for (int k = 0; k < 4; k++) push_src(1, edge_v[k]);
        repeat (4 + NSTAGE + 2) do_cycle();

        // All requesters continuously valid with operand id+1.
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < NREQ; i++) push_src(i, 32'(i + 1));
        repeat (3 * NREQ + NSTAGE + 2) do_cycle();

        // Rotation: requester 2 alone, then 1 and 2 together.
        push_src(2, 32'd100);
        do_cycle();
        push_src(1, 32'd101);
        push_src(2, 32'd102);
        repeat (2 + NSTAGE + 2) do_cycle();

        // Enable dropped with two in flight and requests still pending.
        for (int k = 0; k < 4; k++) push_src(0, 32'(k * 7 - 9));
        push_src(3, 32'd55);
        repeat (2) do_cycle();
        en = 1'b0;
        repeat (NSTAGE + 4) do_cycle();
        en = 1'b1;
        repeat (6 + NSTAGE + 2) do_cycle();

        // Asynchronous reset with the pipeline saturated.
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < NREQ; i++) push_src(i, 32'(200 + 4 * r + i));
        repeat (NSTAGE) do_cycle();
        #2;
        rstn = 1'b0;
        #1;
        chk(resp_valid == '0, "arst_resp_valid", 64'(resp_valid), 64'h0);
        chk(inflight == '0, "arst_inflight", 64'(inflight), 64'h0);
        chk(busy == 1'b0, "arst_busy", 64'(busy), 64'h0);
        clear_model();
        req_valid = '0;
        @(negedge clk);
        #2;
        rstn = 1'b1;
        @(negedge clk);
        repeat (NSTAGE + 3) do_cycle();
        push_src(3, 32'd33);
        push_src(1, 32'd11);
        push_src(0, 32'd10);
        repeat (3 + NSTAGE + 2) do_cycle();

        // Randomised traffic with occasional enable drops.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 3) == 0 && (tail[i] - head[i]) < 6) begin
                    if ($urandom_range(0, 4) == 0) push_src(i, edge_v[$urandom_range(0, 3)]);
                    else push_src(i, $urandom);
                end
            end
            en = ($urandom_range(0, 9) != 0);
            do_cycle();
        end
        en = 1'b1;
        repeat (40) do_cycle();
        chk(sb_q.size() == 0, "drain_empty", 64'(sb_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
